vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/mod_counter.sv | 42 ++++
 rtl/vga_sync.sv | 139 +++++++++++++
 tb/tb_vga_sync.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 VGA timing constants, the derived line and
//                frame totals, and small helpers used by vga_sync and by the
//                downstream pixel-generation blocks.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Sum of the four timing regions of one axis (display, front, sync, back).
    function automatic int unsigned span_total(
        input int unsigned display,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return display + front + sync + back;
    endfunction

    // Counter width for a modulus; a modulus of 1 still needs a 1-bit register.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned C_CLK_DIV   = 2;     // system clocks per pixel

    localparam int unsigned C_H_DISPLAY = 640;   // pixels
    localparam int unsigned C_H_FRONT   = 16;
    localparam int unsigned C_H_SYNC    = 96;
    localparam int unsigned C_H_BACK    = 48;

    localparam int unsigned C_V_DISPLAY = 480;   // lines
    localparam int unsigned C_V_FRONT   = 10;
    localparam int unsigned C_V_SYNC    = 2;
    localparam int unsigned C_V_BACK    = 33;

    localparam int unsigned C_H_TOTAL   = span_total(C_H_DISPLAY, C_H_FRONT, C_H_SYNC, C_H_BACK);
    localparam int unsigned C_V_TOTAL   = span_total(C_V_DISPLAY, C_V_FRONT, C_V_SYNC, C_V_BACK);

    localparam int unsigned C_COUNT_W   = 10;    // width of pixel_x / pixel_y

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo-N up counter with enable. Counts 0..N-1 and wraps;
//                tc is high in the cycle where an enabled increment wraps.
//  Ports       : clk   - system clock
//                rst   - asynchronous active-low reset (count -> 0)
//                en    - advance the count on this clk edge
//                count - current count value
//                tc    - terminal count: en and count == N-1
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = width_of(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] C_LAST = W'(N - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tc ? '0 : r_count + W'(1);
        end
    end

    assign tc    = en && (r_count == C_LAST);
    assign count = r_count;

endmodule : mod_counter
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync
//  Description : VGA sync generator. A clock divider produces the pixel
//                enable, horizontal/vertical counters walk the raster, and
//                sync / blanking / frame-start flags are decoded from the
//                next count and registered so they stay aligned with the
//                counters and glitch-free.
//  Ports       : clk         - system clock
//                rst         - asynchronous active-low reset
//                p_tick      - one-clk pixel enable pulse
//                pixel_x     - horizontal count 0..H_TOTAL-1
//                pixel_y     - vertical count 0..V_TOTAL-1
//                video_on    - inside visible area
//                hsync       - horizontal sync, active low
//                vsync       - vertical sync, active low
//                frame_start - one-clk pulse on the first cycle at (0,0)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = C_CLK_DIV,
    parameter int unsigned H_DISPLAY = C_H_DISPLAY,
    parameter int unsigned H_FRONT   = C_H_FRONT,
    parameter int unsigned H_SYNC    = C_H_SYNC,
    parameter int unsigned H_BACK    = C_H_BACK,
    parameter int unsigned V_DISPLAY = C_V_DISPLAY,
    parameter int unsigned V_FRONT   = C_V_FRONT,
    parameter int unsigned V_SYNC    = C_V_SYNC,
    parameter int unsigned V_BACK    = C_V_BACK
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 p_tick,
    output logic [C_COUNT_W-1:0] pixel_x,
    output logic [C_COUNT_W-1:0] pixel_y,
    output logic                 video_on,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start
);

    localparam int unsigned C_H_PERIOD = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned C_V_PERIOD = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned C_DIV_W    = width_of(CLK_DIV);

    localparam logic [C_COUNT_W-1:0] C_H_VIS    = C_COUNT_W'(H_DISPLAY);
    localparam logic [C_COUNT_W-1:0] C_V_VIS    = C_COUNT_W'(V_DISPLAY);
    localparam logic [C_COUNT_W-1:0] C_HS_FIRST = C_COUNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [C_COUNT_W-1:0] C_HS_LAST  = C_COUNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [C_COUNT_W-1:0] C_VS_FIRST = C_COUNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [C_COUNT_W-1:0] C_VS_LAST  = C_COUNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [C_DIV_W-1:0]   w_div;
    logic                 w_div_tc;
    logic                 w_h_tc;
    logic                 w_v_tc;
    logic [C_COUNT_W-1:0] w_x;
    logic [C_COUNT_W-1:0] w_y;
    logic [C_COUNT_W-1:0] w_next_x;
    logic [C_COUNT_W-1:0] w_next_y;
    logic                 w_div_unused;

    logic r_video_on;
    logic r_hsync;
    logic r_vsync;
    logic r_frame_start;

    // Free-running pixel-clock divider; only its terminal count is consumed.
    mod_counter #(.N(CLK_DIV), .W(C_DIV_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (w_div),
        .tc    (w_div_tc)
    );

    assign w_div_unused = ^w_div;
    assign p_tick       = w_div_tc;

    mod_counter #(.N(C_H_PERIOD), .W(C_COUNT_W)) u_h (
        .clk   (clk),
        .rst   (rst),
        .en    (p_tick),
        .count (w_x),
        .tc    (w_h_tc)
    );

    // w_h_tc already includes p_tick, so lines advance only on the last pixel tick.
    mod_counter #(.N(C_V_PERIOD), .W(C_COUNT_W)) u_v (
        .clk   (clk),
        .rst   (rst),
        .en    (w_h_tc),
        .count (w_y),
        .tc    (w_v_tc)
    );

    // Value the counters will hold after this edge; the flags are decoded from
    // it so that, once registered, they line up with pixel_x/pixel_y.
    always_comb begin
        w_next_x = w_x;
        w_next_y = w_y;
        if (w_h_tc) begin
            w_next_x = '0;
        end else if (p_tick) begin
            w_next_x = w_x + C_COUNT_W'(1);
        end
        if (w_v_tc) begin
            w_next_y = '0;
        end else if (w_h_tc) begin
            w_next_y = w_y + C_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_video_on    <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_video_on    <= (w_next_x < C_H_VIS) && (w_next_y < C_V_VIS);
            r_hsync       <= !((w_next_x >= C_HS_FIRST) && (w_next_x <= C_HS_LAST));
            r_vsync       <= !((w_next_y >= C_VS_FIRST) && (w_next_y <= C_VS_LAST));
            // Only a genuine double wrap marks a frame; a reset restart does not.
            r_frame_start <= w_v_tc;
        end
    end

    assign pixel_x     = w_x;
    assign pixel_y     = w_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule : vga_sync
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync
//  Description : Self-checking bench for vga_sync. Horizontal timing and the
//                divider use their default values; the vertical region is
//                shortened so whole frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync;

    localparam int DIV = 2;
    localparam int HD = 640, HF = 16, HS = 96, HB = 48;
    localparam int VD = 4,   VF = 2,  VS = 2,  VB = 2;
    localparam int HT    = HD + HF + HS + HB;   // 800
    localparam int VT    = VD + VF + VS + VB;   // 10
    localparam int LINE  = DIV * HT;            // 1600 clk
    localparam int FRAME = LINE * VT;           // 16000 clk

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // clk edges seen since the last reset release

    always #5 clk = ~clk;

    vga_sync #(
        .V_DISPLAY (VD),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_tick      (p_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    // Reference: after k edges, k/DIV pixels have elapsed since (0,0).
    function automatic logic [24:0] model(input int kk);
        int   p, x, y;
        logic tk, vo, hs, vs, fs;
        if (kk == 0) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        p  = (kk / DIV) % (HT * VT);
        x  = p % HT;
        y  = p / HT;
        tk = (kk % DIV) == (DIV - 1);
        vo = (x < HD) && (y < VD);
        hs = !((x >= HD + HF) && (x < HD + HF + HS));
        vs = !((y >= VD + VF) && (y < VD + VF + VS));
        fs = (kk % FRAME) == 0;
        return {tk, 10'(x), 10'(y), vo, hs, vs, fs};
    endfunction

    function automatic logic [24:0] observed();
        return {p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) k = k + 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        k   = 0;
        repeat ($urandom_range(2, 5)) begin
            step();
            total++;
            if (observed() !== model(0)) begin
                bad++;
                $display("FAIL reset_state got=%h exp=%h", observed(), model(0));
            end
        end
    endtask

    task automatic test_line();
        int         ticks, max_x, wrap_k;
        logic [9:0] prev_x;
        bit         vec_ok;
        ticks = 0; max_x = 0; wrap_k = -1; prev_x = 10'd0; vec_ok = 1;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < LINE; c++) begin
            step();
            if (vec_ok) begin
                total++;
                if (observed() !== model(k)) begin
                    bad++; vec_ok = 0;
                    $display("FAIL line_vec k=%0d got=%h exp=%h", k, observed(), model(k));
                end
            end
            if (k == 1) begin
                total++;
                if (video_on !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
                    bad++;
                    $display("FAIL first_cycle got x=%0d y=%0d vo=%b exp x=0 y=0 vo=1",
                             pixel_x, pixel_y, video_on);
                end
            end
            if (p_tick) ticks++;
            if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
            if (pixel_x == 10'd0 && prev_x == 10'd799 && wrap_k < 0) wrap_k = k;
            prev_x = pixel_x;
        end
        total++;
        if (ticks != 800) begin bad++; $display("FAIL tick_count got=%0d exp=800", ticks); end
        total++;
        if (max_x != 799) begin bad++; $display("FAIL max_x got=%0d exp=799", max_x); end
        total++;
        if (wrap_k != 1600) begin bad++; $display("FAIL line_period got=%0d exp=1600", wrap_k); end
    endtask

    task automatic test_hsync();
        int low_ticks, first_low;
        bit vec_ok;
        low_ticks = 0; first_low = -1; vec_ok = 1;
        for (int c = 0; c < LINE; c++) begin
            step();
            if (vec_ok) begin
                total++;
                if (observed() !== model(k)) begin
                    bad++; vec_ok = 0;
                    $display("FAIL hsync_vec k=%0d got=%h exp=%h", k, observed(), model(k));
                end
            end
            if (p_tick && !hsync) low_ticks++;
            if (!hsync && first_low < 0) first_low = int'(pixel_x);
        end
        total++;
        if (low_ticks != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", low_ticks); end
        total++;
        if (first_low != 656) begin bad++; $display("FAIL hsync_start got=%0d exp=656", first_low); end
    endtask

    task automatic test_frame();
        int fs_k, max_y, vs_lines, first_vs, vo_ticks, vo_bad;
        bit vec_ok;
        fs_k = -1; max_y = 0; vs_lines = 0; first_vs = -1; vo_ticks = 0; vo_bad = 0; vec_ok = 1;
        #2;
        rst = 1'b0;
        k   = 0;
        #1;
        total++;
        if (observed() !== model(0)) begin
            bad++;
            $display("FAIL frame_reset got=%h exp=%h", observed(), model(0));
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < FRAME + 4 && fs_k < 0; c++) begin
            step();
            if (vec_ok) begin
                total++;
                if (observed() !== model(k)) begin
                    bad++; vec_ok = 0;
                    $display("FAIL frame_vec k=%0d got=%h exp=%h", k, observed(), model(k));
                end
            end
            if (frame_start) fs_k = k;
            if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
            if (p_tick && pixel_x == 10'd0 && !vsync) begin
                vs_lines++;
                if (first_vs < 0) first_vs = int'(pixel_y);
            end
            if (p_tick && video_on) vo_ticks++;
            if (video_on && (pixel_x == 10'd640 || pixel_y == 10'(VD))) vo_bad++;
        end
        total++;
        if (fs_k != FRAME) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", fs_k, FRAME); end
        total++;
        if (max_y != VT - 1) begin bad++; $display("FAIL max_y got=%0d exp=%0d", max_y, VT - 1); end
        total++;
        if (vs_lines != VS) begin bad++; $display("FAIL vsync_lines got=%0d exp=%0d", vs_lines, VS); end
        total++;
        if (first_vs != VD + VF) begin bad++; $display("FAIL vsync_start got=%0d exp=%0d", first_vs, VD + VF); end
        total++;
        if (vo_ticks != HD * VD) begin bad++; $display("FAIL video_ticks got=%0d exp=%0d", vo_ticks, HD * VD); end
        total++;
        if (vo_bad != 0) begin bad++; $display("FAIL video_edge got=%0d exp=0", vo_bad); end
    endtask

    task automatic test_async_reset();
        int yt, target, fs_k;
        bit reached, vec_ok;
        yt      = int'($urandom_range(0, VT - 1));
        target  = DIV * (yt * HT + 700) + 1;
        reached = 0; vec_ok = 1; fs_k = -1;
        for (int c = 0; c < FRAME + 4 && !reached; c++) begin
            step();
            if (vec_ok) begin
                total++;
                if (observed() !== model(k)) begin
                    bad++; vec_ok = 0;
                    $display("FAIL approach_vec k=%0d got=%h exp=%h", k, observed(), model(k));
                end
            end
            if ((k % FRAME) == target) reached = 1;
        end
        total++;
        if (!reached || pixel_x !== 10'd700 || pixel_y !== 10'(yt)) begin
            bad++;
            $display("FAIL reach_point got x=%0d y=%0d exp x=700 y=%0d", pixel_x, pixel_y, yt);
        end
        #2;
        rst = 1'b0;
        k   = 0;
        #1;
        total++;
        if (observed() !== model(0)) begin
            bad++;
            $display("FAIL async_immediate got=%h exp=%h", observed(), model(0));
        end
        repeat ($urandom_range(1, 4)) begin
            step();
            total++;
            if (observed() !== model(0)) begin
                bad++;
                $display("FAIL async_hold got=%h exp=%h", observed(), model(0));
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < FRAME + 4 && fs_k < 0; c++) begin
            step();
            if (vec_ok) begin
                total++;
                if (observed() !== model(k)) begin
                    bad++; vec_ok = 0;
                    $display("FAIL restart_vec k=%0d got=%h exp=%h", k, observed(), model(k));
                end
            end
            if (frame_start) fs_k = k;
        end
        total++;
        if (fs_k != FRAME) begin bad++; $display("FAIL restart_frame got=%0d exp=%0d", fs_k, FRAME); end
    endtask

    task automatic test_random_resets();
        bit vec_ok;
        vec_ok = 1;
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(1, 1500)) begin
                step();
                if (vec_ok) begin
                    total++;
                    if (observed() !== model(k)) begin
                        bad++; vec_ok = 0;
                        $display("FAIL random_vec k=%0d got=%h exp=%h", k, observed(), model(k));
                    end
                end
            end
            #($urandom_range(1, 2));
            rst = 1'b0;
            k   = 0;
            #1;
            total++;
            if (observed() !== model(0)) begin
                bad++;
                $display("FAIL random_reset got=%h exp=%h", observed(), model(0));
            end
            repeat ($urandom_range(0, 2)) step();
            @(negedge clk);
            rst = 1'b1;
        end
        repeat (40) begin
            step();
            if (vec_ok) begin
                total++;
                if (observed() !== model(k)) begin
                    bad++; vec_ok = 0;
                    $display("FAIL random_tail k=%0d got=%h exp=%h", k, observed(), model(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_hsync();
        test_frame();
        test_async_reset();
        test_random_resets();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vga_sync
`default_nettype wire
